// File: rtl/if_id_hazard_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_hazard_reg
// Description : IF/ID pipeline register with load-use hazard detection,
//               one-slot branch/jump flush and pre-split instruction fields.
//               Optional stall/flush statistics counters are enabled by
//               defining IF_ID_HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_hazard_reg #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc_plus4_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic                   id_ex_mem_read,
  input  logic [4:0]             id_ex_rt,
  output logic                   if_en,
  output logic                   id_bubble,
  output logic [PC_WIDTH-1:0]    pc_plus4_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   valid_out,
  output logic [5:0]             opcode_out,
  output logic [4:0]             rs_out,
  output logic [4:0]             rt_out,
  output logic [4:0]             rd_out,
  output logic [31:0]            imm_sext_out
`ifdef IF_ID_HAZARD_STATS_EN
  ,
  output logic [15:0]            stall_count,
  output logic [15:0]            flush_count
`endif
);

  // Opcodes whose rt field is a source operand (R-type, beq, bne, sw).
  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_SW    = 6'h2B;

  // The field slicing below assumes the fixed 32-bit MIPS layout.
  generate
    if (INSTR_WIDTH != 32) begin : g_width_check
      $error("if_id_hazard_reg: INSTR_WIDTH must be 32");
    end
  endgenerate

  logic [PC_WIDTH-1:0]    pc_plus4_q, pc_plus4_d;
  logic [INSTR_WIDTH-1:0] instr_q,    instr_d;
  logic                   valid_q,    valid_d;

  logic w_uses_rt;
  logic w_stall;
  logic w_flush;

  // Hazard detection from the instruction currently held for decode.
  always_comb begin
    w_uses_rt = 1'b0;
    case (instr_q[31:26])
      C_OP_RTYPE, C_OP_BEQ, C_OP_BNE, C_OP_SW: w_uses_rt = 1'b1;
      default:                                 w_uses_rt = 1'b0;
    endcase
    w_stall = valid_q & id_ex_mem_read & (id_ex_rt != 5'd0) &
              ((id_ex_rt == instr_q[25:21]) |
               (w_uses_rt & (id_ex_rt == instr_q[20:16])));
    // A stalled decode instruction is re-evaluated next cycle, so any
    // branch/jump it asserts now must not flush yet.
    w_flush = (branch_taken | jump) & ~w_stall;
  end

  // Next-state selection: stall holds, flush inserts a bubble, else capture.
  always_comb begin
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (w_stall) begin
      pc_plus4_d = pc_plus4_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
    end else if (w_flush) begin
      pc_plus4_d = pc_plus4_in;
      instr_d    = '0;
      valid_d    = 1'b0;
    end else begin
      pc_plus4_d = pc_plus4_in;
      instr_d    = instr_in;
      valid_d    = 1'b1;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_plus4_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IF_ID_HAZARD_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Saturating event counters.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (w_stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
    if (w_flush && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

  assign if_en        = ~w_stall;
  assign id_bubble    = w_stall;
  assign pc_plus4_out = pc_plus4_q;
  assign instr_out    = instr_q;
  assign valid_out    = valid_q;
  assign opcode_out   = instr_q[31:26];
  assign rs_out       = instr_q[25:21];
  assign rt_out       = instr_q[20:16];
  assign rd_out       = instr_q[15:11];
  assign imm_sext_out = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule
`default_nettype wire

// File: tb/tb_if_id_hazard_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_hazard_reg
// Description : Directed self-checking bench for if_id_hazard_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_hazard_reg;

  localparam int PC_WIDTH    = 10;
  localparam int INSTR_WIDTH = 32;

  logic                   clk;
  logic                   reset;
  logic [PC_WIDTH-1:0]    pc_plus4_in;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   branch_taken;
  logic                   jump;
  logic                   id_ex_mem_read;
  logic [4:0]             id_ex_rt;
  logic                   if_en;
  logic                   id_bubble;
  logic [PC_WIDTH-1:0]    pc_plus4_out;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   valid_out;
  logic [5:0]             opcode_out;
  logic [4:0]             rs_out;
  logic [4:0]             rt_out;
  logic [4:0]             rd_out;
  logic [31:0]            imm_sext_out;
`ifdef IF_ID_HAZARD_STATS_EN
  logic [15:0]            stall_count;
  logic [15:0]            flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_id_hazard_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_plus4_in    (pc_plus4_in),
    .instr_in       (instr_in),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .if_en          (if_en),
    .id_bubble      (id_bubble),
    .pc_plus4_out   (pc_plus4_out),
    .instr_out      (instr_out),
    .valid_out      (valid_out),
    .opcode_out     (opcode_out),
    .rs_out         (rs_out),
    .rt_out         (rt_out),
    .rd_out         (rd_out),
    .imm_sext_out   (imm_sext_out)
`ifdef IF_ID_HAZARD_STATS_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    pc_plus4_in    = '0;
    instr_in       = '0;
    branch_taken   = 1'b0;
    jump           = 1'b0;
    id_ex_mem_read = 1'b0;
    id_ex_rt       = 5'd0;
    step();
    step();

    // Reset state
    chk("rst_pc",    32'(pc_plus4_out), 32'd0);
    chk("rst_instr", instr_out,         32'h0);
    chk("rst_valid", 32'(valid_out),    32'd0);
    chk("rst_if_en", 32'(if_en),        32'd1);
    chk("rst_bub",   32'(id_bubble),    32'd0);
    chk("rst_imm",   imm_sext_out,      32'h0);

    // Capture lw $1,0($0)
    reset       = 1'b0;
    pc_plus4_in = 10'd4;
    instr_in    = 32'h8C010000;
    step();
    chk("cap_pc",    32'(pc_plus4_out), 32'd4);
    chk("cap_instr", instr_out,         32'h8C010000);
    chk("cap_valid", 32'(valid_out),    32'd1);
    chk("cap_if_en", 32'(if_en),        32'd1);
    chk("cap_op",    32'(opcode_out),   32'h23);
    chk("cap_rt",    32'(rt_out),       32'd1);

    // Capture add $3,$1,$2 then load-use on $1
    pc_plus4_in = 10'd8;
    instr_in    = 32'h00221820;
    step();
    chk("add_rs", 32'(rs_out), 32'd1);
    chk("add_rt", 32'(rt_out), 32'd2);
    chk("add_rd", 32'(rd_out), 32'd3);
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd1;
    pc_plus4_in    = 10'd12;
    instr_in       = 32'h20440005;  // addi $4,$2,5
    #1;
    chk("lu_if_en", 32'(if_en),     32'd0);
    chk("lu_bub",   32'(id_bubble), 32'd1);
    step();
    chk("lu_hold_instr", instr_out,         32'h00221820);
    chk("lu_hold_pc",    32'(pc_plus4_out), 32'd8);
    chk("lu_hold_valid", 32'(valid_out),    32'd1);
    id_ex_mem_read = 1'b0;
    #1;
    chk("lu_rel_if_en", 32'(if_en), 32'd1);
    step();
    chk("lu_next_instr", instr_out,         32'h20440005);
    chk("lu_next_pc",    32'(pc_plus4_out), 32'd12);
    chk("addi_imm",      imm_sext_out,      32'h00000005);

    // addi: rt is a destination, so a load into rt is not a hazard
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd4;
    pc_plus4_in    = 10'd16;
    instr_in       = 32'h00001020;  // add $2,$0,$0
    #1;
    chk("addi_rt_nostall", 32'(if_en), 32'd1);
    step();

    // Load into $0 never stalls
    id_ex_rt = 5'd0;
    #1;
    chk("r0_nostall", 32'(if_en),     32'd1);
    chk("r0_nobub",   32'(id_bubble), 32'd0);

    // beq $5,$6,-2 : rt is a source
    id_ex_mem_read = 1'b0;
    pc_plus4_in    = 10'd20;
    instr_in       = 32'h10A6FFFE;
    step();
    chk("beq_imm", imm_sext_out, 32'hFFFFFFFE);
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd6;
    #1;
    chk("beq_rt_stall", 32'(if_en), 32'd0);
    id_ex_mem_read = 1'b0;

    // Branch flush
    branch_taken = 1'b1;
    pc_plus4_in  = 10'd8;
    instr_in     = 32'h8C050004;
    step();
    chk("br_instr", instr_out,         32'h0);
    chk("br_valid", 32'(valid_out),    32'd0);
    chk("br_pc",    32'(pc_plus4_out), 32'd8);
    branch_taken   = 1'b0;
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd0;
    #1;
    chk("bubble_nostall", 32'(if_en), 32'd1);
    id_ex_mem_read = 1'b0;

    // Jump flush
    pc_plus4_in = 10'd24;
    instr_in    = 32'h00221820;
    step();
    chk("pre_j_valid", 32'(valid_out), 32'd1);
    jump        = 1'b1;
    pc_plus4_in = 10'd40;
    step();
    chk("j_instr", instr_out,         32'h0);
    chk("j_valid", 32'(valid_out),    32'd0);
    chk("j_pc",    32'(pc_plus4_out), 32'd40);
    jump = 1'b0;

    // Stall overrides a branch
    pc_plus4_in = 10'd28;
    instr_in    = 32'h00221820;
    step();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd2;
    branch_taken   = 1'b1;
    pc_plus4_in    = 10'd100;
    instr_in       = 32'hFFFFFFFF;
    step();
    chk("stbr_instr", instr_out,         32'h00221820);
    chk("stbr_valid", 32'(valid_out),    32'd1);
    chk("stbr_pc",    32'(pc_plus4_out), 32'd28);

    // Async reset mid-stall, no clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pc",    32'(pc_plus4_out), 32'd0);
    chk("ar_instr", instr_out,         32'h0);
    chk("ar_valid", 32'(valid_out),    32'd0);
    chk("ar_if_en", 32'(if_en),        32'd1);
    chk("ar_bub",   32'(id_bubble),    32'd0);
    chk("ar_rs",    32'(rs_out),       32'd0);
    branch_taken   = 1'b0;
    id_ex_mem_read = 1'b0;

    // Three stalls, then two flushes
    step();
    reset       = 1'b0;
    pc_plus4_in = 10'd4;
    instr_in    = 32'h00221820;
`ifdef IF_ID_HAZARD_STATS_EN
    chk("st_rst_stall", 32'(stall_count), 32'd0);
    chk("st_rst_flush", 32'(flush_count), 32'd0);
`endif
    step();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd1;
    step();
    step();
    step();
    chk("st3_hold", instr_out, 32'h00221820);
    id_ex_mem_read = 1'b0;
    jump           = 1'b1;
    step();
    step();
    jump = 1'b0;
    chk("fl2_valid", 32'(valid_out), 32'd0);
`ifdef IF_ID_HAZARD_STATS_EN
    chk("st_stall_cnt", 32'(stall_count), 32'd3);
    chk("st_flush_cnt", 32'(flush_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("st_clr_stall", 32'(stall_count), 32'd0);
    chk("st_clr_flush", 32'(flush_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
